// File: rtl/music_box_pkg.sv
// Shared types and constants for the music box note sequencer.
package music_box_pkg;

    localparam int unsigned MIN_FREQ = 100;
    localparam int unsigned MAX_FREQ = 8000;
    localparam int unsigned FS_HZ    = 32000;

    // Upper clamp never exceeds Nyquist of the generator sample rate
    localparam int unsigned FREQ_CEIL = (MAX_FREQ < FS_HZ / 2) ? MAX_FREQ : FS_HZ / 2;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StWaitZero,
        StGap,
        StDone
    } seq_state_t;

    function automatic logic [13:0] clamp_freq(input logic [13:0] freq);
        if (freq < 14'(MIN_FREQ)) return 14'(MIN_FREQ);
        if (freq > 14'(FREQ_CEIL)) return 14'(FREQ_CEIL);
        return freq;
    endfunction

endpackage

// File: rtl/duration_timer.sv
// Millisecond prescaler plus 8-bit ms countdown; expire flags the last tick of the interval.
module duration_timer #(
    parameter int unsigned TICKS_PER_MS = 32
) (
    input  logic       CLK_32KHz,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_ms,
    input  logic       count,
    output logic       expire
);

    localparam int unsigned     PreW    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_MS - 1);

    logic [PreW-1:0] presc_q;
    logic [7:0]      ms_q;

    assign expire = (ms_q <= 8'd1) && (presc_q == PreLast);

    always_ff @(posedge CLK_32KHz or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            ms_q    <= '0;
        end else if (load) begin
            presc_q <= '0;
            ms_q    <= load_ms;
        end else if (count) begin
            if (presc_q == PreLast) begin
                presc_q <= '0;
                ms_q    <= ms_q - 8'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays a table of (frequency, duration) notes with articulation gaps and
// phase-aligned note-off.
module note_sequencer
    import music_box_pkg::*;
#(
    parameter int unsigned NOTE_COUNT   = 16,
    parameter int unsigned TICKS_PER_MS = 32,
    parameter int unsigned GAP_MS       = 2,
    parameter int unsigned ZERO_TIMEOUT = 320
) (
    input  logic                          CLK_32KHz,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop_en,
    input  logic                          wr_en,
    input  logic [$clog2(NOTE_COUNT)-1:0] wr_addr,
    input  logic [13:0]                   wr_freq,
    input  logic [7:0]                    wr_dur,
    input  logic                          indexZero,
    output logic [13:0]                   outputFrequency,
    output logic                          gen_enable,
    output logic                          busy,
    output logic [$clog2(NOTE_COUNT)-1:0] note_index,
    output logic                          done
);

    localparam int unsigned     IdxW    = $clog2(NOTE_COUNT);
    localparam int unsigned     ZcW     = $clog2(ZERO_TIMEOUT + 1);
    localparam logic [7:0]      GapMs   = 8'(GAP_MS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NOTE_COUNT - 1);
    localparam logic [ZcW-1:0]  ZcLast  = ZcW'(ZERO_TIMEOUT - 1);

    seq_state_t      state_q;
    logic [13:0]     freq_tbl [NOTE_COUNT];
    logic [7:0]      dur_tbl  [NOTE_COUNT];
    logic [ZcW-1:0]  zero_cnt_q;

    logic [IdxW-1:0] next_idx;
    logic [IdxW-1:0] apply_idx;
    logic            end_of_song;
    logic            zero_exit;
    logic            adv;
    logic            apply_go;
    logic            go_done;
    logic            tmr_load;
    logic [7:0]      tmr_load_ms;
    logic            tmr_count;
    logic            tmr_expire;

    duration_timer #(
        .TICKS_PER_MS(TICKS_PER_MS)
    ) u_timer (
        .CLK_32KHz(CLK_32KHz),
        .reset    (reset),
        .load     (tmr_load),
        .load_ms  (tmr_load_ms),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    // Decide which entry (if any) gets applied on the coming edge
    always_comb begin
        next_idx    = note_index + 1'b1;
        end_of_song = (note_index == LastIdx) || (dur_tbl[next_idx] == 8'd0);
        zero_exit   = indexZero || !gen_enable || (zero_cnt_q == ZcLast);
        adv         = 1'b0;
        apply_go    = 1'b0;
        go_done     = 1'b0;
        apply_idx   = '0;
        tmr_count   = 1'b0;
        tmr_load    = 1'b0;
        tmr_load_ms = GapMs;
        if (!stop) begin
            case (state_q)
                StIdle:     apply_go = start;
                StPlay:     tmr_count = 1'b1;
                StWaitZero: begin
                    if (zero_exit) begin
                        if (GAP_MS == 0) adv = 1'b1;
                        else             tmr_load = 1'b1;
                    end
                end
                StGap: begin
                    tmr_count = 1'b1;
                    adv       = tmr_expire;
                end
                default: ;
            endcase
        end
        if (adv) begin
            if (end_of_song && !loop_en) begin
                go_done = 1'b1;
            end else begin
                apply_go  = 1'b1;
                apply_idx = end_of_song ? '0 : next_idx;
            end
        end
        if (apply_go) begin
            tmr_load    = 1'b1;
            tmr_load_ms = dur_tbl[apply_idx];
        end
    end

    always_ff @(posedge CLK_32KHz or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            outputFrequency <= '0;
            gen_enable      <= 1'b0;
            busy            <= 1'b0;
            note_index      <= '0;
            done            <= 1'b0;
            zero_cnt_q      <= '0;
            for (int i = 0; i < NOTE_COUNT; i++) begin
                freq_tbl[i] <= '0;
                dur_tbl[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            if (wr_en && (state_q == StIdle)) begin
                freq_tbl[wr_addr] <= wr_freq;
                dur_tbl[wr_addr]  <= wr_dur;
            end
            if (stop && (state_q != StIdle)) begin
                state_q    <= StIdle;
                gen_enable <= 1'b0;
                busy       <= 1'b0;
            end else if (apply_go) begin
                note_index <= apply_idx;
                busy       <= 1'b1;
                if (dur_tbl[apply_idx] == 8'd0) begin
                    state_q    <= StDone;
                    gen_enable <= 1'b0;
                    done       <= 1'b1;
                end else begin
                    state_q <= StPlay;
                    // A rest keeps the last pitch so the generator sees no glitch
                    if (freq_tbl[apply_idx] != 14'd0) begin
                        outputFrequency <= clamp_freq(freq_tbl[apply_idx]);
                        gen_enable      <= 1'b1;
                    end else begin
                        gen_enable <= 1'b0;
                    end
                end
            end else if (go_done) begin
                state_q    <= StDone;
                gen_enable <= 1'b0;
                done       <= 1'b1;
            end else begin
                case (state_q)
                    StPlay: begin
                        if (tmr_expire) begin
                            state_q    <= StWaitZero;
                            zero_cnt_q <= '0;
                        end
                    end
                    StWaitZero: begin
                        zero_cnt_q <= zero_cnt_q + 1'b1;
                        if (zero_exit) begin
                            state_q    <= StGap;
                            gen_enable <= 1'b0;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed scoreboard bench for note_sequencer at default parameters.
module tb_note_sequencer;

    logic        CLK_32KHz = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [13:0] wr_freq;
    logic [7:0]  wr_dur;
    logic        indexZero;
    logic [13:0] outputFrequency;
    logic        gen_enable;
    logic        busy;
    logic [3:0]  note_index;
    logic        done;

    int n_asserts = 0;
    int n_fail    = 0;
    int done_cnt  = 0;

    localparam int KGen  = 0;
    localparam int KIdx  = 1;
    localparam int KDone = 2;
    localparam int NotePeriod = 32 + 1 + 64;

    typedef struct {
        string tag;
        int    cyc;
        int    freq;
        int    gen;
        int    busy;
        int    idx;
        int    done;
    } exp_t;

    exp_t exp_q[$];

    note_sequencer dut (
        .CLK_32KHz      (CLK_32KHz),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .loop_en        (loop_en),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_freq        (wr_freq),
        .wr_dur         (wr_dur),
        .indexZero      (indexZero),
        .outputFrequency(outputFrequency),
        .gen_enable     (gen_enable),
        .busy           (busy),
        .note_index     (note_index),
        .done           (done)
    );

    always #5 CLK_32KHz = ~CLK_32KHz;

    always @(posedge CLK_32KHz) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK_32KHz);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int cyc, input int freq, input int gen,
                        input int bsy, input int idx, input int dn);
        exp_t e;
        e.tag  = tag;
        e.cyc  = cyc;
        e.freq = freq;
        e.gen  = gen;
        e.busy = bsy;
        e.idx  = idx;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    // Negative expected fields are don't-care
    task automatic pop_check(input int cyc);
        exp_t e;
        chk("sb.nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        if (e.cyc  >= 0) chk({e.tag, ".cycles"}, cyc, e.cyc);
        if (e.freq >= 0) chk({e.tag, ".freq"}, int'(outputFrequency), e.freq);
        if (e.gen  >= 0) chk({e.tag, ".gen_enable"}, int'(gen_enable), e.gen);
        if (e.busy >= 0) chk({e.tag, ".busy"}, int'(busy), e.busy);
        if (e.idx  >= 0) chk({e.tag, ".note_index"}, int'(note_index), e.idx);
        if (e.done >= 0) chk({e.tag, ".done"}, int'(done), e.done);
    endtask

    function automatic int sig(input int kind);
        case (kind)
            KGen:    return int'(gen_enable);
            KIdx:    return int'(note_index);
            default: return int'(done);
        endcase
    endfunction

    // Returns cycles until the output reaches val, or -1 when the budget runs out
    task automatic wait_until(input int kind, input int val, input int budget, output int cycles);
        int i = 0;
        cycles = -1;
        while (cycles < 0 && i < budget) begin
            tick();
            i++;
            if (sig(kind) == val) cycles = i;
        end
    endtask

    task automatic write_entry(input int addr, input int freq, input int dur);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_freq = 14'(freq);
        wr_dur  = 8'(dur);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int c;
        int done_ref;

        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0; indexZero = 1'b1;
        #1;
        push("reset", -1, 0, 0, 0, 0, 0);
        pop_check(-1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Tone, rest, end marker
        write_entry(0, 440, 3);
        write_entry(1, 0, 2);
        write_entry(2, 0, 0);
        push("s1.start", -1, 440, 1, 1, 0, 0);
        push("s1.gap",   97, 440, 0, 1, 0, 0);
        push("s1.rest",  64, 440, 0, 1, 1, 0);
        push("s1.done", 129,  -1, 0, 1, -1, 1);
        push("s1.idle",  -1,  -1, 0, 0, -1, 0);
        pulse_start();
        pop_check(-1);
        wait_until(KGen, 0, 500, c);  pop_check(c);
        wait_until(KIdx, 1, 500, c);  pop_check(c);
        wait_until(KDone, 1, 500, c); pop_check(c);
        tick();
        pop_check(-1);

        // Phase zero never arrives
        indexZero = 1'b0;
        write_entry(0, 1000, 1);
        write_entry(1, 0, 0);
        push("tmo.start", -1, 1000, 1, 1, 0, 0);
        push("tmo.fall", 352, 1000, 0, 1, 0, 0);
        push("tmo.done",  64,   -1, 0, 1, -1, 1);
        pulse_start();
        pop_check(-1);
        wait_until(KGen, 0, 1000, c); pop_check(c);
        wait_until(KDone, 1, 500, c); pop_check(c);
        tick();
        indexZero = 1'b1;

        // Frequency clamping at both ends
        write_entry(0, 50, 1);
        write_entry(1, 9000, 1);
        write_entry(2, 0, 0);
        push("clamp.low",  -1,  100, 1, 1, 0, 0);
        push("clamp.high", 97, 8000, 1, 1, 1, 0);
        push("clamp.done", 97,   -1, 0, 1, -1, 1);
        pulse_start();
        pop_check(-1);
        wait_until(KIdx, 1, 500, c);  pop_check(c);
        wait_until(KDone, 1, 500, c); pop_check(c);
        tick();

        // Full table, looping then finishing
        for (int i = 0; i < 16; i++) write_entry(i, 200 + 10 * i, 1);
        loop_en  = 1'b1;
        done_ref = done_cnt;
        push("loop.start", -1, 200, 1, 1, 0, 0);
        push("loop.last", 15 * NotePeriod, 350, 1, 1, 15, 0);
        push("loop.wrap", NotePeriod, 200, 1, 1, 0, 0);
        pulse_start();
        pop_check(-1);
        wait_until(KIdx, 15, 3000, c); pop_check(c);
        wait_until(KIdx, 0, 500, c);   pop_check(c);
        chk("loop.no_done", done_cnt, done_ref);
        loop_en = 1'b0;
        push("end.last", 15 * NotePeriod, 350, 1, 1, 15, 0);
        push("end.done", NotePeriod, -1, 0, 1, -1, 1);
        wait_until(KIdx, 15, 3000, c); pop_check(c);
        wait_until(KDone, 1, 500, c);  pop_check(c);
        tick();

        // Start and stop together from IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        push("ss.idle", -1, -1, 0, 0, -1, 0);
        pop_check(-1);
        repeat (5) tick();
        push("ss.still_idle", -1, -1, 0, 0, -1, 0);
        pop_check(-1);

        // Stop mid-PLAY; a write during PLAY must be dropped
        push("stp.play", -1, 200, 1, 1, 0, 0);
        pulse_start();
        pop_check(-1);
        write_entry(0, 0, 0);
        repeat (5) tick();
        done_ref = done_cnt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push("stp.idle", -1, -1, 0, 0, -1, 0);
        pop_check(-1);
        repeat (20) tick();
        chk("stp.no_done", done_cnt, done_ref);
        push("stp.nowrite", -1, 200, 1, 1, 0, 0);
        pulse_start();
        pop_check(-1);

        // Asynchronous reset mid-PLAY clears the table
        repeat (10) tick();
        reset = 1'b1;
        #1;
        push("rst.async", -1, 0, 0, 0, 0, 0);
        pop_check(-1);
        tick();
        reset = 1'b0;
        tick();
        push("rst.empty", -1, 0, 0, 1, 0, 1);
        push("rst.idle",  -1, 0, 0, 0, 0, 0);
        pulse_start();
        pop_check(-1);
        tick();
        pop_check(-1);

        chk("sb.drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
